countdown_timer: RTL and testbench

- Preliminary-period countdown. On a start request it loads a level-dependent number of seconds and decrements once per rising edge of the slow Clk1Hz input.
- Shows the remaining seconds on one active-low 7-segment digit.
- Pulses doneCounting when the count expires.
- Sits inside the preliminary-period controller, between the level register and the game-period start logic. Runs entirely in the Clk100M domain.

---
 rtl/countdown_pkg.sv | 20 ++
 rtl/seg7_decoder.sv | 17 +
 rtl/countdown_timer.sv | 108 ++++++++++
 tb/tb_countdown_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer block.
package countdown_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry i is the pattern for digit i.
    localparam logic [9:0][7:0] DIGITS = {
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
        8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit value to active-low 7-segment pattern; values above 9 blank.
module seg7_decoder
    import countdown_pkg::*;
(
    input  logic [CNT_W-1:0] value,
    output logic [7:0]       pattern
);

    // Table lookup with blank as the fallback for out-of-range values
    always_comb begin
        pattern = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (value == CNT_W'(i)) pattern = DIGITS[i];
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Preliminary-period countdown: loads a level-dependent length on a start edge
// and decrements once per synchronised Clk1Hz rise, showing the digit on seg.
// Optional COUNTDOWN_DONE_HOLD_EN: after expiry hold "0" on the display in a
// DONE state until the next start edge instead of blanking.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int MIN_SECONDS = 3,
    parameter int MAX_SECONDS = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk100M,
    input  logic       Rst,
    input  logic       Clk1Hz,
    input  logic [3:0] curLevel,
    input  logic       start,
    output logic       doneCounting,
    output logic [7:0] seg
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_d;
    logic                   start_q;
    logic                   tick;
    logic                   start_edge;

    logic [4:0]             len_sum;
    logic [CNT_W-1:0]       len;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_dec;
    logic [7:0]             seg_len;
    logic [7:0]             seg_dec;
    state_t                 state;

    // Synchronise Clk1Hz and keep the previous samples for edge detection
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            sync_q   <= '0;
            synced_d <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            sync_q[0] <= Clk1Hz;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            synced_d <= sync_q[SYNC_STAGES-1];
            start_q  <= start;
        end
    end

    assign tick       = sync_q[SYNC_STAGES-1] & ~synced_d;
    assign start_edge = start & ~start_q;

    // 5-bit sum so level 15 cannot wrap before the clamp
    assign len_sum   = 5'(MIN_SECONDS) + {1'b0, curLevel};
    assign len       = (len_sum > 5'(MAX_SECONDS)) ? CNT_W'(MAX_SECONDS) : len_sum[CNT_W-1:0];
    assign count_dec = count - CNT_W'(1);

    // Decode both candidate next values so seg updates on the same edge as count
    seg7_decoder u_dec_len (.value(len),       .pattern(seg_len));
    seg7_decoder u_dec_cnt (.value(count_dec), .pattern(seg_dec));

    // Countdown FSM with registered count, display and done pulse
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            state        <= IDLE;
            count        <= '0;
            doneCounting <= 1'b0;
            seg          <= SEG_BLANK;
        end else begin
            doneCounting <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state <= COUNT;
                        count <= len;
                        seg   <= seg_len;
                    end
                end
                COUNT: begin
                    // A restart takes priority over a coincident tick
                    if (start_edge) begin
                        count <= len;
                        seg   <= seg_len;
                    end else if (tick) begin
                        if (count > CNT_W'(1)) begin
                            count <= count_dec;
                            seg   <= seg_dec;
                        end else begin
                            count        <= '0;
                            doneCounting <= 1'b1;
`ifdef COUNTDOWN_DONE_HOLD_EN
                            state        <= DONE;
                            seg          <= DIGITS[0];
`else
                            state        <= IDLE;
                            seg          <= SEG_BLANK;
`endif
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    seg   <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a cycle-level reference model.
module tb_countdown_timer;

    localparam int MIN_S = 3;
    localparam int MAX_S = 9;
    localparam int SYNC  = 2;
`ifdef COUNTDOWN_DONE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif
    localparam logic [7:0] END_SEG = HOLD ? 8'hC0 : 8'hFF;

    logic       Clk100M = 1'b0;
    logic       Rst     = 1'b1;
    logic       Clk1Hz  = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] curLevel = 4'd0;
    logic       doneCounting;
    logic [7:0] seg;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    bit go = 1'b0;

    countdown_timer #(
        .MIN_SECONDS(MIN_S),
        .MAX_SECONDS(MAX_S),
        .SYNC_STAGES(SYNC)
    ) dut (
        .Clk100M(Clk100M),
        .Rst(Rst),
        .Clk1Hz(Clk1Hz),
        .curLevel(curLevel),
        .start(start),
        .doneCounting(doneCounting),
        .seg(seg)
    );

    always #5 Clk100M = ~Clk100M;

    // Reference model: remaining seconds plus flags, driven by sampled inputs
    logic [7:0] dig [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    bit h [SYNC+2];
    bit ps, active, held, m_done;
    int rem = 0;

    always @(posedge Clk100M) begin : model
        bit tk, se;
        for (int i = SYNC + 1; i > 0; i--) h[i] = h[i-1];
        h[0] = Clk1Hz;
        if (Rst) begin
            for (int i = 0; i < SYNC + 2; i++) h[i] = 1'b0;
            ps = 0; active = 0; held = 0; rem = 0; m_done = 0;
        end else begin
            tk = h[SYNC] && !h[SYNC+1];
            se = start && !ps;
            ps = start;
            m_done = 0;
            if (se) begin
                rem = MIN_S + int'(curLevel);
                if (rem > MAX_S) rem = MAX_S;
                active = 1; held = 0;
            end else if (active && tk) begin
                rem = rem - 1;
                if (rem <= 0) begin
                    rem = 0; active = 0; m_done = 1; held = HOLD;
                end
            end
        end
    end

    function automatic logic [7:0] exp_seg();
        if (active) return dig[rem];
        return held ? 8'hC0 : 8'hFF;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge Clk100M) begin
        if (go) begin
            checks++;
            if (seg !== exp_seg()) begin
                errors++;
                $display("FAIL seg_vs_model t=%0t got=%h exp=%h", $time, seg, exp_seg());
            end
            checks++;
            if (doneCounting !== m_done) begin
                errors++;
                $display("FAIL done_vs_model t=%0t got=%b exp=%b", $time, doneCounting, m_done);
            end
            if (doneCounting === 1'b1) done_seen++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk100M);
        #1;
    endtask

    task automatic rise1hz();
        Clk1Hz = 1'b1; cyc(4);
        Clk1Hz = 1'b0; cyc(4);
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset with a start pulse that must be ignored
        cyc(1);
        go = 1'b1;
        pulse_start();
        cyc(1);
        chk("reset_seg", 32'(seg), 32'hFF);
        chk("reset_done", 32'(doneCounting), 32'h0);
        Rst = 1'b0;
        cyc(2);
        chk("idle_after_reset", 32'(seg), 32'hFF);

        // Level 0: 3 -> 2 -> 1 -> expiry
        curLevel = 4'd0;
        pulse_start();
        chk("lvl0_load", 32'(seg), 32'hB0);
        rise1hz();
        chk("lvl0_two", 32'(seg), 32'hA4);
        rise1hz();
        chk("lvl0_one", 32'(seg), 32'hF9);
        rise1hz();
        chk("lvl0_end", 32'(seg), 32'(END_SEG));
        chk("lvl0_done_count", done_seen, 1);

        // Clamp at level 9; level change mid-count is ignored
        curLevel = 4'd9;
        pulse_start();
        chk("lvl9_load", 32'(seg), 32'h90);
        curLevel = 4'd2;
        repeat (8) rise1hz();
        chk("lvl9_last", 32'(seg), 32'hF9);
        rise1hz();
        chk("lvl9_done_count", done_seen, 2);

        // Level 15 clamps to 9; restart coincident with a tick at count 5
        curLevel = 4'd15;
        pulse_start();
        chk("lvl15_load", 32'(seg), 32'h90);
        repeat (4) rise1hz();
        chk("lvl15_at5", 32'(seg), 32'h92);
        Clk1Hz = 1'b1;
        cyc(2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("restart_reload", 32'(seg), 32'h90);
        Clk1Hz = 1'b0;
        cyc(4);
        chk("restart_no_dec", 32'(seg), 32'h90);
        chk("restart_no_done", done_seen, 2);

        // Held start fires once; must fall before re-arming
        curLevel = 4'd1;
        start = 1'b1;
        cyc(1);
        chk("held_load", 32'(seg), 32'h99);
        repeat (4) rise1hz();
        chk("held_end", 32'(seg), 32'(END_SEG));
        repeat (2) rise1hz();
        chk("held_no_rearm", 32'(seg), 32'(END_SEG));
        chk("held_done_count", done_seen, 3);
        start = 1'b0;
        cyc(1);
        pulse_start();
        chk("rearm_load", 32'(seg), 32'h99);

        // Reset mid-count at 4
        Rst = 1'b1;
        cyc(1);
        Rst = 1'b0;
        chk("midreset_seg", 32'(seg), 32'hFF);
        rise1hz();
        chk("midreset_tick_ignored", 32'(seg), 32'hFF);
        chk("midreset_no_done", done_seen, 3);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
